// File: rtl/baud_gen.sv
// UART baud generator: fractional divider producing oversample, mid-bit and bit strobes
// plus a 50% duty baud clock. Divisor updates go through shadow registers.
module baud_gen #(
    parameter int DIV_W    = 16,
    parameter int FRAC_W   = 4,
    parameter int OVS      = 16,
    parameter int DEF_INT  = 27,
    parameter int DEF_FRAC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              load,
    input  logic              sync,
    output logic              ovs_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic              oclk,
    output logic              upd_pend
);
    localparam int OVS_W = $clog2(OVS);

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [OVS_W-1:0]  ovs_cnt_q, ovs_cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              c_q, c_d;
    logic [DIV_W-1:0]  act_int_q, act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [DIV_W-1:0]  shd_int_q, shd_int_d;
    logic [FRAC_W-1:0] shd_frac_q, shd_frac_d;
    logic              upd_pend_q, upd_pend_d;
    logic              ovs_tick_q, ovs_tick_d;
    logic              mid_tick_q, mid_tick_d;
    logic              bit_tick_q, bit_tick_d;
    logic              oclk_q, oclk_d;

    logic [DIV_W-1:0]  int_cl;
    logic [DIV_W:0]    pm1;
    logic              wrap;
    logic              pend_eff;
    logic [FRAC_W-1:0] frac_use;
    logic [FRAC_W:0]   acc_sum;
    logic [OVS_W-1:0]  ovs_nxt;

    // A load in the same cycle as a wrap/sync is captured first, then applied.
    assign shd_int_d  = load ? div_int  : shd_int_q;
    assign shd_frac_d = load ? div_frac : shd_frac_q;
    assign pend_eff   = load | upd_pend_q;

    assign int_cl   = (act_int_q < DIV_W'(2)) ? DIV_W'(2) : act_int_q;
    assign pm1      = {1'b0, int_cl} + {{DIV_W{1'b0}}, c_q} - (DIV_W+1)'(1);
    assign wrap     = ({1'b0, cnt_q} == pm1);
    assign frac_use = pend_eff ? shd_frac_d : act_frac_q;
    assign acc_sum  = {1'b0, acc_q} + {1'b0, frac_use};
    assign ovs_nxt  = (ovs_cnt_q == OVS_W'(OVS - 1)) ? '0 : ovs_cnt_q + OVS_W'(1);

    always_comb begin
        cnt_d      = cnt_q;
        ovs_cnt_d  = ovs_cnt_q;
        acc_d      = acc_q;
        c_d        = c_q;
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        upd_pend_d = load | upd_pend_q;
        ovs_tick_d = 1'b0;
        mid_tick_d = 1'b0;
        bit_tick_d = 1'b0;
        oclk_d     = oclk_q;

        if (!en) begin
            cnt_d     = '0;
            ovs_cnt_d = '0;
            acc_d     = '0;
            c_d       = 1'b0;
            oclk_d    = 1'b0;
            // Idle: a shadow captured last cycle becomes active now.
            if (upd_pend_q) begin
                act_int_d  = shd_int_q;
                act_frac_d = shd_frac_q;
                upd_pend_d = load;
            end
        end else if (sync) begin
            cnt_d     = '0;
            ovs_cnt_d = '0;
            acc_d     = '0;
            c_d       = 1'b0;
            oclk_d    = 1'b0;
            if (pend_eff) begin
                act_int_d  = shd_int_d;
                act_frac_d = shd_frac_d;
                upd_pend_d = 1'b0;
            end
        end else if (wrap) begin
            cnt_d      = '0;
            acc_d      = acc_sum[FRAC_W-1:0];
            c_d        = acc_sum[FRAC_W];
            ovs_tick_d = 1'b1;
            ovs_cnt_d  = ovs_nxt;
            bit_tick_d = (ovs_nxt == '0);
            mid_tick_d = (ovs_nxt == OVS_W'(OVS / 2));
            if (bit_tick_d) begin
                oclk_d = 1'b1;
            end else if (mid_tick_d) begin
                oclk_d = 1'b0;
            end
            // The wrap itself already used the new fraction; the new integer starts next interval.
            if (pend_eff) begin
                act_int_d  = shd_int_d;
                act_frac_d = shd_frac_d;
                upd_pend_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            ovs_cnt_q  <= '0;
            acc_q      <= '0;
            c_q        <= 1'b0;
            act_int_q  <= DIV_W'(DEF_INT);
            act_frac_q <= FRAC_W'(DEF_FRAC);
            shd_int_q  <= '0;
            shd_frac_q <= '0;
            upd_pend_q <= 1'b0;
            ovs_tick_q <= 1'b0;
            mid_tick_q <= 1'b0;
            bit_tick_q <= 1'b0;
            oclk_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ovs_cnt_q  <= ovs_cnt_d;
            acc_q      <= acc_d;
            c_q        <= c_d;
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            shd_int_q  <= shd_int_d;
            shd_frac_q <= shd_frac_d;
            upd_pend_q <= upd_pend_d;
            ovs_tick_q <= ovs_tick_d;
            mid_tick_q <= mid_tick_d;
            bit_tick_q <= bit_tick_d;
            oclk_q     <= oclk_d;
        end
    end

    assign ovs_tick = ovs_tick_q;
    assign mid_tick = mid_tick_q;
    assign bit_tick = bit_tick_q;
    assign oclk     = oclk_q;
    assign upd_pend = upd_pend_q;

endmodule

// File: tb/tb_baud_gen.sv
// Directed bench for baud_gen: divisor vector table plus hand-built sequences for
// bit/mid timing, live reload, sync alignment and mid-operation reset.
module tb_baud_gen;
    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OVS    = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              load = 1'b0;
    logic              sync = 1'b0;
    logic [DIV_W-1:0]  div_int = '0;
    logic [FRAC_W-1:0] div_frac = '0;
    logic              ovs_tick, mid_tick, bit_tick, oclk, upd_pend;

    int checks = 0;
    int errors = 0;

    baud_gen #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS), .DEF_INT(27), .DEF_FRAC(2)) dut (
        .clk(clk), .rst(rst), .en(en), .div_int(div_int), .div_frac(div_frac),
        .load(load), .sync(sync), .ovs_tick(ovs_tick), .mid_tick(mid_tick),
        .bit_tick(bit_tick), .oclk(oclk), .upd_pend(upd_pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DIV_W-1:0]  di;
        logic [FRAC_W-1:0] df;
        int g0, g1, g2, g3, g4;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic evt(input int w);
        case (w)
            0:       return ovs_tick;
            1:       return mid_tick;
            default: return bit_tick;
        endcase
    endfunction

    // Cycles until the selected strobe is seen; bounded so a dead DUT still ends.
    task automatic wait_evt(input int w, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!evt(w) && n < 2000);
    endtask

    task automatic load_idle(input int di, input int df);
        load = 1'b1;
        div_int = DIV_W'(di);
        div_frac = FRAC_W'(df);
        step();
        load = 1'b0;
        step();
    endtask

    initial begin
        vec_t vecs[8];
        int   gexp[5];
        int   n;

        vecs[0] = '{16'd4, 4'd0,  4, 4, 4, 4, 4};
        vecs[1] = '{16'd4, 4'd8,  4, 4, 5, 4, 5};
        vecs[2] = '{16'd1, 4'd0,  2, 2, 2, 2, 2};
        vecs[3] = '{16'd0, 4'd0,  2, 2, 2, 2, 2};
        vecs[4] = '{16'd3, 4'd12, 3, 3, 4, 4, 4};
        vecs[5] = '{16'd2, 4'd15, 2, 2, 3, 3, 3};
        vecs[6] = '{16'd5, 4'd1,  5, 5, 5, 5, 5};
        vecs[7] = '{16'd6, 4'd8,  6, 6, 7, 6, 7};

        // Reset state
        repeat (3) step();
        check("rst_ovs", ovs_tick, 0);
        check("rst_mid", mid_tick, 0);
        check("rst_bit", bit_tick, 0);
        check("rst_oclk", oclk, 0);
        check("rst_pend", upd_pend, 0);

        // Default divisor 27 + 2/16: eight 27s then a 28
        rst = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wait_evt(0, n);
            check($sformatf("def_gap%0d", i), n, (i == 8) ? 28 : 27);
        end
        en = 1'b0;
        step();
        check("en0_ovs", ovs_tick, 0);

        // Vector table: idle load, pend pulse, then interval sequence
        for (int v = 0; v < 8; v++) begin
            load = 1'b1;
            div_int = vecs[v].di;
            div_frac = vecs[v].df;
            step();
            load = 1'b0;
            check($sformatf("v%0d_pend_set", v), upd_pend, 1);
            step();
            check($sformatf("v%0d_pend_clr", v), upd_pend, 0);
            gexp = '{vecs[v].g0, vecs[v].g1, vecs[v].g2, vecs[v].g3, vecs[v].g4};
            en = 1'b1;
            for (int i = 0; i < 5; i++) begin
                wait_evt(0, n);
                check($sformatf("v%0d_gap%0d", v, i), n, gexp[i]);
            end
            en = 1'b0;
            step();
            check($sformatf("v%0d_off_oclk", v), oclk, 0);
        end

        // Bit/mid timing and oclk duty at int=4
        load_idle(4, 0);
        en = 1'b1;
        wait_evt(1, n);
        check("t1_first_mid", n, 32);
        wait_evt(2, n);
        check("t1_first_bit", n, 32);
        check("t1_oclk_hi", oclk, 1);
        wait_evt(1, n);
        check("t1_bit_mid", n, 32);
        check("t1_oclk_lo", oclk, 0);
        wait_evt(2, n);
        check("t1_mid_bit", n, 32);

        // Live reload to int=8 mid-interval
        step();
        load = 1'b1;
        div_int = 16'd8;
        div_frac = 4'd0;
        step();
        load = 1'b0;
        check("t3_pend", upd_pend, 1);
        wait_evt(0, n);
        check("t3_cur_gap", n, 2);
        check("t3_pend_clr", upd_pend, 0);
        wait_evt(0, n);
        check("t3_new_gap0", n, 8);
        wait_evt(0, n);
        check("t3_new_gap1", n, 8);

        // Sync 10 clk after mid_tick at int=4
        en = 1'b0;
        step();
        load_idle(4, 0);
        en = 1'b1;
        wait_evt(1, n);
        repeat (10) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        wait_evt(0, n);
        check("t4_first_ovs", n, 4);
        wait_evt(1, n);
        check("t4_mid", n, 28);
        wait_evt(2, n);
        check("t4_bit", n, 32);
        repeat (5) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("t4_sync_oclk", oclk, 0);

        // Sync on the cycle a wrap would fire suppresses the tick
        wait_evt(0, n);
        repeat (3) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("t4_suppress", ovs_tick, 0);
        wait_evt(0, n);
        check("t4_after_sup", n, 4);

        // Sync and load together apply the new divisor immediately
        sync = 1'b1;
        load = 1'b1;
        div_int = 16'd5;
        step();
        sync = 1'b0;
        load = 1'b0;
        check("sl_pend", upd_pend, 0);
        wait_evt(0, n);
        check("sl_gap", n, 5);

        // Two loads before the wrap: last one wins
        step();
        load = 1'b1;
        div_int = 16'd7;
        step();
        div_int = 16'd3;
        step();
        load = 1'b0;
        wait_evt(0, n);
        check("lw_cur_gap", n, 2);
        wait_evt(0, n);
        check("lw_new_gap", n, 3);

        // Async reset mid-bit with a pending update
        wait_evt(2, n);
        step();
        load = 1'b1;
        div_int = 16'd9;
        step();
        load = 1'b0;
        check("t5_pre_oclk", oclk, 1);
        check("t5_pre_pend", upd_pend, 1);
        rst = 1'b1;
        #1;
        check("t5_rst_oclk", oclk, 0);
        check("t5_rst_pend", upd_pend, 0);
        check("t5_rst_ovs", ovs_tick, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wait_evt(0, n);
            check($sformatf("t5_gap%0d", i), n, (i == 8) ? 28 : 27);
        end

        // int=1 and int=0 both clamp to 2
        en = 1'b0;
        step();
        load_idle(1, 0);
        en = 1'b1;
        wait_evt(2, n);
        check("t6_int1_bit", n, 32);
        en = 1'b0;
        step();
        load_idle(0, 0);
        en = 1'b1;
        wait_evt(2, n);
        check("t6_int0_bit0", n, 32);
        wait_evt(2, n);
        check("t6_int0_bit1", n, 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
